// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM port controller.
package mem_ctrl_pkg;

  localparam int RAM_ADDR_W = 17;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_IF  = 3'd1,
    S_RD_MEM = 3'd2,
    S_WR_MEM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Byte count for a load/store length code; the illegal code 3 behaves as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_bytes = 3'd1;
      LEN_HALF: len_bytes = 3'd2;
      LEN_WORD: len_bytes = 3'd4;
      default:  len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide synchronous RAM between instruction fetch and load/store,
// sequencing each request into 1, 2 or 4 little-endian byte transactions.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o
);

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_cnt;
  logic [2:0]          r_n;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [23:0]         r_buf;
  logic                r_is_mem;
  logic [31:0]         r_if_inst;
  logic [31:0]         r_mem_rdata;
  logic [31:0]         w_word;
  logic                w_unused;

  assign w_unused = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  // Next-state selection; MEM wins arbitration and a dropped fetch request aborts the read.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          w_next_state = mem_we_i ? S_WR_MEM : S_RD_MEM;
        end else if (if_req_i) begin
          w_next_state = S_RD_IF;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RD_IF: begin
        if (!if_req_i) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == r_n) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RD_IF;
        end
      end
      S_RD_MEM: begin
        if (r_cnt == r_n) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RD_MEM;
        end
      end
      S_WR_MEM: begin
        if (r_cnt == r_n - 3'd1) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WR_MEM;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Final assembled value: the last byte arrives on ram_din_i in the capture cycle.
  always_comb begin
    case (r_n)
      3'd1:    w_word = {24'd0, ram_din_i};
      3'd2:    w_word = {16'd0, ram_din_i, r_buf[7:0]};
      default: w_word = {ram_din_i, r_buf};
    endcase
  end

  // State, byte counter, request latches and assembled result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_buf       <= 24'd0;
      r_is_mem    <= 1'b0;
      r_if_inst   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 3'd0;
          if (mem_req_i) begin
            r_is_mem <= 1'b1;
            r_addr   <= mem_addr_i[ADDR_W-1:0];
            r_n      <= len_bytes(mem_len_i);
            r_wdata  <= mem_wdata_i;
          end else if (if_req_i) begin
            r_is_mem <= 1'b0;
            r_addr   <= if_addr_i[ADDR_W-1:0];
            r_n      <= 3'd4;
            r_wdata  <= 32'd0;
          end
        end
        S_RD_IF, S_RD_MEM: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == r_n) begin
            if (r_state == S_RD_MEM) begin
              r_mem_rdata <= w_word;
            end else if (if_req_i) begin
              r_if_inst <= w_word;
            end
          end else begin
            case (r_cnt)
              3'd1:    r_buf[7:0]   <= ram_din_i;
              3'd2:    r_buf[15:8]  <= ram_din_i;
              3'd3:    r_buf[23:16] <= ram_din_i;
              default: r_buf        <= r_buf;
            endcase
          end
        end
        S_WR_MEM: r_cnt <= r_cnt + 3'd1;
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

  // RAM port drive; the write strobe is also masked directly by reset.
  always_comb begin
    ram_addr_o = '0;
    ram_dout_o = 8'd0;
    ram_wr_o   = 1'b0;
    if (r_state == S_WR_MEM) begin
      ram_addr_o = r_addr + ADDR_W'(r_cnt);
      ram_wr_o   = !rst;
      case (r_cnt)
        3'd0:    ram_dout_o = r_wdata[7:0];
        3'd1:    ram_dout_o = r_wdata[15:8];
        3'd2:    ram_dout_o = r_wdata[23:16];
        default: ram_dout_o = r_wdata[31:24];
      endcase
    end else if ((r_state == S_RD_IF || r_state == S_RD_MEM) && r_cnt < r_n) begin
      ram_addr_o = r_addr + ADDR_W'(r_cnt);
    end else begin
      ram_addr_o = '0;
    end
  end

  assign if_done_o      = (r_state == S_DONE) && !r_is_mem;
  assign mem_done_o     = (r_state == S_DONE) && r_is_mem;
  assign if_inst_o      = r_if_inst;
  assign mem_rdata_o    = r_mem_rdata;
  assign stallreq_if_o  = if_req_i && !if_done_o;
  assign stallreq_mem_o = mem_req_i && !mem_done_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random loads/stores/fetches
// checked cycle by cycle against a byte-array reference memory.
module tb_mem_ctrl;

  localparam int AW   = 17;
  localparam int MSZ  = 1 << AW;
  localparam int MASK = MSZ - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic [31:0]   if_inst;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_len;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic          ram_wr;
  logic [7:0]    ram_din;
  logic          stall_if;
  logic          stall_mem;

  logic [7:0] ram     [0:MSZ-1];
  logic [7:0] ref_mem [0:MSZ-1];

  int n_chk  = 0;
  int n_fail = 0;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_inst_o(if_inst), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .ram_addr_o(ram_addr), .ram_dout_o(ram_dout), .ram_wr_o(ram_wr), .ram_din_i(ram_din),
    .stallreq_if_o(stall_if), .stallreq_mem_o(stall_mem)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registered read data, write on strobe.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    ram[a & MASK]     = v;
    ref_mem[a & MASK] = v;
  endtask

  function automatic logic [31:0] model_read(input int a, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) & MASK]) << (8 * i));
    return v;
  endfunction

  // Runs one request starting in the current cycle (T0) and checks every cycle through done.
  task automatic do_op(input bit is_if, input bit we, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n, lat, a;
    logic [31:0] exp_a, exp_d, exp_data;
    bit exp_w;
    a = int'(addr) & MASK;
    n = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
    lat = (!is_if && we) ? n + 1 : n + 2;
    exp_data = model_read(a, n);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      exp_w = !is_if && we && k >= 1 && k <= n;
      exp_a = (k >= 1 && k <= n) ? 32'((a + k - 1) & MASK) : 32'd0;
      exp_d = exp_w ? ((wdata >> (8 * (k - 1))) & 32'hFF) : 32'd0;
      chk("ram_addr", 32'(ram_addr), exp_a);
      chk("ram_wr", 32'(ram_wr), 32'(exp_w));
      chk("ram_dout", 32'(ram_dout), exp_d);
      chk(is_if ? "if_done" : "mem_done", 32'(is_if ? if_done : mem_done), 32'(k == lat));
      chk("other_done", 32'(is_if ? mem_done : if_done), 32'd0);
      chk("stallreq", 32'(is_if ? stall_if : stall_mem), 32'(k < lat));
      if (k == lat && is_if) chk("if_inst", if_inst, exp_data);
      if (k == lat && !is_if && !we) chk("mem_rdata", mem_rdata, exp_data);
      @(posedge clk); #1;
    end
    if (is_if) if_req = 1'b0;
    else mem_req = 1'b0;
    if (!is_if && we)
      for (int i = 0; i < n; i++) ref_mem[(a + i) & MASK] = 8'((wdata >> (8 * i)) & 32'hFF);
  endtask

  initial begin
    logic [31:0] r, lo;
    for (int i = 0; i < MSZ; i++) begin
      ram[i]     = 8'((i * 7) ^ (i >> 8));
      ref_mem[i] = 8'((i * 7) ^ (i >> 8));
    end
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;

    // Directed: word fetch, word store, byte load.
    poke(32'h1000, 8'h78); poke(32'h1001, 8'h56); poke(32'h1002, 8'h34); poke(32'h1003, 8'h12);
    do_op(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'd0);
    chk("fetch_value", if_inst, 32'h1234_5678);
    do_op(1'b0, 1'b1, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'd0);
    chk("store_readback", mem_rdata, 32'hDEAD_BEEF);
    poke(32'h31, 8'h9C);
    do_op(1'b0, 1'b0, 2'd0, 32'h0000_0031, 32'd0);
    chk("load_byte", mem_rdata, 32'h0000_009C);

    // Simultaneous requests: half load served first, then the fetch.
    poke(32'h40, 8'h34); poke(32'h41, 8'h12);
    if_req = 1'b1; if_addr = 32'h1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h40;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      chk("sim_mem_done", 32'(mem_done), 32'(k == 4));
      chk("sim_if_done", 32'(if_done), 32'(k == 11));
      chk("sim_stall_if", 32'(stall_if), 32'(k <= 10));
      chk("sim_stall_mem", 32'(stall_mem), 32'(k < 4));
      chk("sim_ram_addr", 32'(ram_addr),
          (k == 1 || k == 2) ? 32'(32'h40 + k - 1) :
          (k >= 6 && k <= 9) ? 32'(32'h1000 + k - 6) : 32'd0);
      if (k == 4) chk("sim_rdata", mem_rdata, 32'h0000_1234);
      if (k == 11) chk("sim_inst", if_inst, 32'h1234_5678);
      @(posedge clk); #1;
      if (k == 4) mem_req = 1'b0;
      if (k == 11) if_req = 1'b0;
    end

    // Fetch abort in T2, then a fresh fetch from T3.
    if_req = 1'b1; if_addr = 32'h2000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_t1_addr", 32'(ram_addr), 32'h2000);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("abort_t2_done", 32'(if_done), 32'd0);
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 2'd2, 32'h0000_2004, 32'd0);

    // Reset during a word store: only the first two bytes land.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h50; mem_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_st_t1", {ram_wr, 7'd0, ram_dout, 15'(ram_addr)}, {1'b1, 7'd0, 8'h0D, 15'h50});
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_st_t2", {ram_wr, 7'd0, ram_dout, 15'(ram_addr)}, {1'b1, 7'd0, 8'hF0, 15'h51});
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    chk("rst_st_wr_gated", 32'(ram_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_st_no_done", 32'(mem_done), 32'd0);
    chk("rst_st_idle_addr", 32'(ram_addr), 32'd0);
    chk("rst_st_rdata_clr", mem_rdata, 32'd0);
    @(posedge clk); #1;
    ref_mem[32'h50] = 8'h0D; ref_mem[32'h51] = 8'hF0;
    do_op(1'b0, 1'b0, 2'd2, 32'h0000_0050, 32'd0);

    // Address wrap at the top of RAM.
    do_op(1'b1, 1'b0, 2'd2, 32'h0001_FFFF, 32'd0);

    // Random traffic with truncated upper address bits.
    for (int t = 0; t < 60; t++) begin
      r  = $urandom();
      lo = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) lo = 32'h1FFFC + 32'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            {r[31:17], lo[16:0]}, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
